// File: rtl/vc_vr_mux_converter.sv
// Credit-based virtual-channel input side muxed onto a single valid/ready output.
// Each VC has its own FIFO. A round-robin arbiter picks which VC is presented downstream.
module vc_vr_mux_converter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_VC     = 2,
  parameter int CREDIT_NUM = 2,
  localparam int VCW       = $clog2(NUM_VC),
  localparam int CW        = $clog2(CREDIT_NUM + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic [VCW-1:0]        s_vc_i,
  input  logic                  s_valid_i,
  output logic [NUM_VC-1:0]     s_credit_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [VCW-1:0]        m_vc_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  err_o
);

  localparam int PW = (CREDIT_NUM > 1) ? $clog2(CREDIT_NUM) : 1;

  logic [DATA_WIDTH-1:0] mem_q    [NUM_VC][CREDIT_NUM];
  logic [PW-1:0]         wr_ptr_q [NUM_VC];
  logic [PW-1:0]         rd_ptr_q [NUM_VC];
  logic [CW-1:0]         occ_q    [NUM_VC];
  logic [CW-1:0]         pend_q   [NUM_VC];

  logic [NUM_VC-1:0] not_empty, push, pop, emit, credit_q;
  logic [VCW-1:0]    rr_ptr_q, rr_gnt, grant, lock_vc_q;
  logic              lock_q, vc_ok, drop, xfer, err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CREDIT_NUM - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      not_empty[v] = (occ_q[v] != '0);
    end
  end

  // Round-robin search from rr_ptr_q; first non-empty VC wins.
  always_comb begin
    rr_gnt = rr_ptr_q;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (not_empty[(int'(rr_ptr_q) + i) % NUM_VC]) begin
        rr_gnt = VCW'((int'(rr_ptr_q) + i) % NUM_VC);
      end
    end
  end

  // Handshake: a beat moves when m_valid_o & m_ready_i at a rising edge. Once
  // m_valid_o is stalled, the grant is locked so m_vc_o/m_data_o hold until the transfer.
  assign grant     = lock_q ? lock_vc_q : rr_gnt;
  assign m_valid_o = |not_empty;
  assign m_vc_o    = grant;
  assign m_data_o  = mem_q[grant][rd_ptr_q[grant]];
  assign xfer      = m_valid_o && m_ready_i;
  assign s_credit_o = credit_q;
  assign err_o     = err_q;

  always_comb begin
    vc_ok = (int'(s_vc_i) < NUM_VC);
    for (int v = 0; v < NUM_VC; v++) begin
      push[v] = s_valid_i && vc_ok && (s_vc_i == VCW'(v)) && (occ_q[v] != CW'(CREDIT_NUM));
      pop[v]  = xfer && (grant == VCW'(v));
      emit[v] = (pend_q[v] != '0);
    end
    drop = s_valid_i && !(|push);
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push[v]) mem_q[v][wr_ptr_q[v]] <= s_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        occ_q[v]    <= '0;
        pend_q[v]   <= CW'(CREDIT_NUM);
      end
      credit_q  <= '0;
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push[v]) wr_ptr_q[v] <= ptr_inc(wr_ptr_q[v]);
        if (pop[v])  rd_ptr_q[v] <= ptr_inc(rd_ptr_q[v]);
        occ_q[v]  <= occ_q[v] + CW'(push[v]) - CW'(pop[v]);
        // A credit is emitted whenever one is pending, so the counter cannot pass CREDIT_NUM.
        pend_q[v] <= pend_q[v] + CW'(pop[v]) - CW'(emit[v]);
      end
      credit_q  <= emit;
      if (xfer) rr_ptr_q <= VCW'((int'(grant) + 1) % NUM_VC);
      lock_q    <= m_valid_o && !m_ready_i;
      lock_vc_q <= grant;
      if (drop) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_vr_mux_converter.sv
// Directed bench for vc_vr_mux_converter: default instance plus a 3-VC, 4-credit instance.
module tb_vc_vr_mux_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance (NUM_VC=2, CREDIT_NUM=2)
  logic [7:0] s_data;
  logic       s_vc;
  logic       s_valid;
  logic [1:0] s_credit;
  logic [7:0] m_data;
  logic       m_vc;
  logic       m_valid;
  logic       m_ready;
  logic       err;

  // second instance (NUM_VC=3, CREDIT_NUM=4)
  logic [7:0] b_s_data;
  logic [1:0] b_s_vc;
  logic       b_s_valid;
  logic [2:0] b_s_credit;
  logic [7:0] b_m_data;
  logic [1:0] b_m_vc;
  logic       b_m_valid;
  logic       b_m_ready;
  logic       b_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seq_d[4];
  logic       seq_vc[4];

  vc_vr_mux_converter dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data), .s_vc_i(s_vc), .s_valid_i(s_valid), .s_credit_o(s_credit),
    .m_data_o(m_data), .m_vc_o(m_vc), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .err_o(err)
  );

  vc_vr_mux_converter #(.DATA_WIDTH(8), .NUM_VC(3), .CREDIT_NUM(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(b_s_data), .s_vc_i(b_s_vc), .s_valid_i(b_s_valid), .s_credit_o(b_s_credit),
    .m_data_o(b_m_data), .m_vc_o(b_m_vc), .m_valid_o(b_m_valid), .m_ready_i(b_m_ready),
    .err_o(b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    s_data = '0; s_vc = '0; s_valid = 1'b0; m_ready = 1'b0;
    b_s_data = '0; b_s_vc = '0; b_s_valid = 1'b0; b_m_ready = 1'b0;
  endtask

  // Reset, check reset values, then watch the initial credit burst drain.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("rst_valid_a", m_valid, 0);
    check("rst_credit_a", s_credit, 0);
    check("rst_err_a", err, 0);
    check("rst_valid_b", b_m_valid, 0);
    check("rst_credit_b", b_s_credit, 0);
    check("rst_err_b", b_err, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("init_credit_a", s_credit, (i < 2) ? 2'b11 : 2'b00);
      check("init_credit_b", b_s_credit, (i < 4) ? 3'b111 : 3'b000);
      check("init_valid_a", m_valid, 0);
    end
  endtask

  task automatic push_a(input logic vc, input logic [7:0] d);
    s_valid = 1'b1; s_vc = vc; s_data = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int avail, sent, xfers, first, last;
    idle_inputs();

    // reset behaviour and initial credits
    do_reset();

    // one beat per VC, ready high
    m_ready = 1'b1;
    s_valid = 1'b1; s_vc = 1'b0; s_data = 8'hA1;
    @(negedge clk);
    check("t35_valid0", m_valid, 1);
    check("t35_vc0", m_vc, 0);
    check("t35_data0", m_data, 8'hA1);
    s_vc = 1'b1; s_data = 8'hB1;
    @(negedge clk);
    s_valid = 1'b0;
    check("t35_vc1", m_vc, 1);
    check("t35_data1", m_data, 8'hB1);
    check("t35_credit_a", s_credit, 2'b00);
    @(negedge clk);
    check("t35_valid_end", m_valid, 0);
    check("t35_credit_b", s_credit, 2'b01);
    @(negedge clk);
    check("t35_credit_c", s_credit, 2'b10);
    @(negedge clk);
    check("t35_credit_d", s_credit, 2'b00);

    // fill both VCs, stall, then drain alternating
    do_reset();
    seq_d[0] = 8'hD0; seq_vc[0] = 1'b0;
    seq_d[1] = 8'hE0; seq_vc[1] = 1'b1;
    seq_d[2] = 8'hD1; seq_vc[2] = 1'b0;
    seq_d[3] = 8'hE1; seq_vc[3] = 1'b1;
    for (int k = 0; k < 4; k++) push_a(seq_vc[k], seq_d[k]);
    for (int i = 0; i < 5; i++) begin
      check("t36_stall_valid", m_valid, 1);
      check("t36_stall_vc", m_vc, 0);
      check("t36_stall_data", m_data, 8'hD0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t36_drain_vc", m_vc, seq_vc[k]);
      check("t36_drain_data", m_data, seq_d[k]);
      @(negedge clk);
    end
    check("t36_empty", m_valid, 0);

    // a stalled grant on VC1 must survive a later VC0 arrival
    m_ready = 1'b0;
    push_a(1'b1, 8'h5A);
    check("lock_vc_a", m_vc, 1);
    push_a(1'b0, 8'h3C);
    check("lock_vc_b", m_vc, 1);
    check("lock_data_b", m_data, 8'h5A);
    m_ready = 1'b1;
    @(negedge clk);
    check("lock_next_vc", m_vc, 0);
    check("lock_next_data", m_data, 8'h3C);
    @(negedge clk);
    check("lock_empty", m_valid, 0);

    // third push into full VC0 is dropped
    do_reset();
    push_a(1'b0, 8'h11);
    push_a(1'b0, 8'h22);
    push_a(1'b0, 8'h33);
    check("t37_err", err, 1);
    check("t37_head", m_data, 8'h11);
    m_ready = 1'b1;
    @(negedge clk);
    check("t37_second", m_data, 8'h22);
    check("t37_err_hold", err, 1);
    @(negedge clk);
    check("t37_empty", m_valid, 0);
    check("t37_err_sticky", err, 1);

    // push into full VC with a same-cycle pop is still dropped
    do_reset();
    push_a(1'b0, 8'h01);
    push_a(1'b0, 8'h02);
    check("t18_err_before", err, 0);
    s_valid = 1'b1; s_vc = 1'b0; s_data = 8'h03; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("t18_err", err, 1);
    check("t18_head", m_data, 8'h02);
    @(negedge clk);
    check("t18_empty", m_valid, 0);

    // out-of-range VC on the 3-VC instance, then reset clears it
    b_s_valid = 1'b1; b_s_vc = 2'd3; b_s_data = 8'h77;
    @(negedge clk);
    b_s_valid = 1'b0;
    check("t38_err", b_err, 1);
    check("t38_valid", b_m_valid, 0);
    @(negedge clk);
    check("t38_err_sticky", b_err, 1);
    do_reset();

    // credit-limited streaming on VC0 of the 4-credit instance
    b_m_ready = 1'b1;
    avail = 4; sent = 0; xfers = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (b_m_valid) begin
        if (exp_q.size() == 0) begin
          check("t39_extra_beat", 1, 0);
        end else begin
          check("t39_data", b_m_data, exp_q.pop_front());
        end
        check("t39_vc", b_m_vc, 0);
        xfers++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (b_s_credit[0]) avail++;
      if (avail > 0 && sent < 30) begin
        b_s_valid = 1'b1; b_s_vc = 2'd0; b_s_data = 8'(sent * 7 + 3);
        exp_q.push_back(8'(sent * 7 + 3));
        avail--;
        sent++;
      end else begin
        b_s_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("t39_count", xfers, 30);
    check("t39_no_bubble", last - first + 1, 30);
    check("t39_err", b_err, 0);
    check("t39_q_empty", exp_q.size(), 0);
    check("t39_credits_back", avail, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
